truth_table_sequencer: RTL and testbench
========================================

Name: truth_table_sequencer

Overview:
- Sequencer for the team's 3-input boolean function bank (six functions: EX, A–E).
- On request, walks {x,y,z} through all 8 minterms, one per clock, and captures the selected function's output into an 8-bit truth-table word.
- Optionally compares the captured table against a caller-supplied expected word.
- Replaces open-loop testbench sweeping with a self-contained, handshaked engine.

Parameters:
- NUM_FN, 6, number of implemented functions; fn_sel values >= NUM_FN are illegal.
- NVARS, 3, number of input variables; fixed at 3, so the table is 2**NVARS = 8 bits.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  request pulse; accepted only while busy=0.
- fn_sel  in  3  function select, sampled on accept: 0=EX x'+(y'.z'), 1=A x.(y+z')', 2=B (x+y')'.z', 3=C (x.y')'.z, 4=D (x.y)'.z, 5=E (x'+y).(y+z).
- check_en  in  1  sampled on accept; 1 enables comparison.
- expected  in  8  sampled on accept; bit i is the expected value at minterm i.
- busy  out  1  high from the cycle after accept until done.
- done  out  1  one-cycle pulse when the result is valid.
- x, y, z  out  1 each  current minterm drive, {x,y,z} = idx.
- table_out  out  8  last completed truth table; bit i = f(x=i[2], y=i[1], z=i[0]).
- mismatch  out  1  |(table_out ^ exp_q) when check was enabled; otherwise 0.
- mismatch_mask  out  8  table_out ^ exp_q when check was enabled; otherwise 0.
- sel_err  out  1  the last request had an illegal fn_sel.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, idx=0, and all outputs 0: busy, done, x, y, z, table_out, mismatch, mismatch_mask, sel_err. Shadow and latched registers are also cleared.
- Reset mid-sweep: same as above; the partial table is discarded.
- FSM states: IDLE, SWEEP, DONE.
- IDLE:
  - start=1 latches fn_q, chk_q and exp_q, and sets idx=0.
  - Legal fn_sel -> SWEEP. Illegal fn_sel -> DONE with sel_err=1.
- SWEEP (8 cycles, idx 0..7):
  - {x,y,z} is driven from idx.
  - The function output is combinational from x, y, z and fn_q.
  - Each edge writes shadow[idx] and increments idx.
  - At idx=7, the capture edge moves to DONE; idx wraps to 0.
- DONE (1 cycle):
  - done=1.
  - table_out <= shadow, or 0 if sel_err.
  - mismatch and mismatch_mask are updated from the new table.
  - Next state: IDLE.
- busy=1 in SWEEP and DONE.
- Latency: start accepted at edge 0; SWEEP occupies cycles 1–8; done is high in cycle 9.
- Illegal select: done appears in cycle 1.
- Outputs hold: table_out, mismatch, mismatch_mask and sel_err hold until the next DONE. sel_err clears on the next legal request.
- Simultaneous events:
  - start while busy is ignored; no queueing.
  - start in the same cycle as done is ignored, because busy=1.
  - Back-to-back requests need start in the first IDLE cycle after DONE.
- Input changes: fn_sel, expected and check_en changing during a sweep have no effect.
- x, y, z are 0 in IDLE.

Decomposition:
- Package truth_table_pkg:
  - FN_EX..FN_E select constants (3-bit).
  - State enum.
  - Golden table constants: GOLD_EX=8'h1F, GOLD_A=8'h20, GOLD_B=8'h04, GOLD_C=8'h8A, GOLD_D=8'h2A, GOLD_E=8'hCE.
- Sub-module boolean_fn_bank:
  - Purely combinational.
  - Inputs: x, y, z and a 3-bit select.
  - Output: one bit; 0 for illegal selects.
  - Instantiated once by the sequencer.

Test Plan:
- Reset: rst_n=0 mid-sweep (fn_sel=5, 4 cycles in) -> all outputs 0 asynchronously. After release, state is IDLE, busy=0.
- Full sweep: fn_sel=0, check_en=0 -> x,y,z step 000..111 over cycles 1–8. done in cycle 9, table_out=8'h1F, mismatch=0, mismatch_mask=0.
- All functions: sweep each of fn_sel=0..5 with check_en=1, expected=GOLD_* -> tables 1F, 20, 04, 8A, 2A, CE; mismatch=0 each time.
- Mismatch: fn_sel=3, check_en=1, expected=8'h8B -> table_out=8'h8A, mismatch=1, mismatch_mask=8'h01.
- Illegal select: fn_sel=6 -> done in cycle 1, sel_err=1, table_out=0. A following legal request (fn_sel=1) -> sel_err=0, table_out=8'h20.
- Handshake: start held high through the whole sweep and change fn_sel to 4 mid-sweep -> exactly one done, table reflects the original select. start in the cycle after done -> new sweep accepted.

Source files
------------

// File: rtl/truth_table_sequencer_pkg.sv
// Shared constants for the truth-table sequencer: function selects, FSM states, golden tables.
package truth_table_pkg;

    localparam int unsigned NUM_FN = 6;
    localparam int unsigned NVARS  = 3;
    localparam int unsigned TBL_W  = 1 << NVARS;

    localparam logic [2:0] FN_EX = 3'd0;
    localparam logic [2:0] FN_A  = 3'd1;
    localparam logic [2:0] FN_B  = 3'd2;
    localparam logic [2:0] FN_C  = 3'd3;
    localparam logic [2:0] FN_D  = 3'd4;
    localparam logic [2:0] FN_E  = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SWEEP,
        ST_DONE
    } state_t;

    localparam logic [TBL_W-1:0] GOLD_EX = 8'h1F;
    localparam logic [TBL_W-1:0] GOLD_A  = 8'h20;
    localparam logic [TBL_W-1:0] GOLD_B  = 8'h04;
    localparam logic [TBL_W-1:0] GOLD_C  = 8'h8A;
    localparam logic [TBL_W-1:0] GOLD_D  = 8'h2A;
    localparam logic [TBL_W-1:0] GOLD_E  = 8'hCE;

endpackage

// File: rtl/boolean_fn_bank.sv
// Combinational bank of the six 3-input boolean functions; illegal selects yield 0.
module boolean_fn_bank
    import truth_table_pkg::*;
(
    input  logic       x,
    input  logic       y,
    input  logic       z,
    input  logic [2:0] sel,
    output logic       f
);

    always_comb begin
        f = 1'b0;
        case (sel)
            FN_EX:   f = ~x | (~y & ~z);
            FN_A:    f = x & ~(y | ~z);
            FN_B:    f = ~(x | ~y) & ~z;
            FN_C:    f = ~(x & ~y) & z;
            FN_D:    f = ~(x & y) & z;
            FN_E:    f = (~x | y) & (y | z);
            default: f = 1'b0;
        endcase
    end

endmodule

// File: rtl/truth_table_sequencer.sv
// Handshaked engine that sweeps all 8 minterms through the selected function and
// captures/compares the resulting truth table.
module truth_table_sequencer
    import truth_table_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       fn_sel,
    input  logic             check_en,
    input  logic [TBL_W-1:0] expected,
    output logic             busy,
    output logic             done,
    output logic             x,
    output logic             y,
    output logic             z,
    output logic [TBL_W-1:0] table_out,
    output logic             mismatch,
    output logic [TBL_W-1:0] mismatch_mask,
    output logic             sel_err
);

    state_t             state;
    logic [NVARS-1:0]   idx;
    logic [2:0]         fn_q;
    logic               chk_q;
    logic [TBL_W-1:0]   exp_q;
    logic [TBL_W-1:0]   shadow;
    logic               fn_out;
    logic               sel_legal_c;
    logic [TBL_W-1:0]   tbl_c;
    logic [TBL_W-1:0]   mask_c;

    // Minterm drive comes straight from the index flops; idx is 0 outside SWEEP.
    assign {x, y, z} = idx;

    boolean_fn_bank u_bank (
        .x   (x),
        .y   (y),
        .z   (z),
        .sel (fn_q),
        .f   (fn_out)
    );

    // Table as it stands after the current capture edge; complete when idx is 7.
    always_comb begin
        sel_legal_c = 32'(fn_sel) < NUM_FN;
        tbl_c       = shadow;
        tbl_c[idx]  = fn_out;
        mask_c      = chk_q ? (tbl_c ^ exp_q) : '0;
    end

    // Result registers are loaded on the edge that enters DONE so they are valid with done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            idx           <= '0;
            fn_q          <= '0;
            chk_q         <= 1'b0;
            exp_q         <= '0;
            shadow        <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            table_out     <= '0;
            mismatch      <= 1'b0;
            mismatch_mask <= '0;
            sel_err       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    idx  <= '0;
                    busy <= 1'b0;
                    if (start) begin
                        fn_q  <= fn_sel;
                        chk_q <= check_en;
                        exp_q <= expected;
                        busy  <= 1'b1;
                        if (sel_legal_c) begin
                            state   <= ST_SWEEP;
                            sel_err <= 1'b0;
                        end else begin
                            state         <= ST_DONE;
                            done          <= 1'b1;
                            sel_err       <= 1'b1;
                            table_out     <= '0;
                            mismatch      <= check_en & (|expected);
                            mismatch_mask <= check_en ? expected : '0;
                        end
                    end
                end
                ST_SWEEP: begin
                    shadow[idx] <= fn_out;
                    idx         <= idx + NVARS'(1);
                    if (idx == NVARS'(TBL_W - 1)) begin
                        state         <= ST_DONE;
                        done          <= 1'b1;
                        table_out     <= tbl_c;
                        mismatch      <= |mask_c;
                        mismatch_mask <= mask_c;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    idx   <= '0;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    idx   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Directed self-checking bench for truth_table_sequencer.
module tb_truth_table_sequencer;
    import truth_table_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [2:0] fn_sel;
    logic       check_en;
    logic [7:0] expected;
    logic       busy;
    logic       done;
    logic       x;
    logic       y;
    logic       z;
    logic [7:0] table_out;
    logic       mismatch;
    logic [7:0] mismatch_mask;
    logic       sel_err;

    int tests_run;
    int tests_failed;

    truth_table_sequencer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .fn_sel        (fn_sel),
        .check_en      (check_en),
        .expected      (expected),
        .busy          (busy),
        .done          (done),
        .x             (x),
        .y             (y),
        .z             (z),
        .table_out     (table_out),
        .mismatch      (mismatch),
        .mismatch_mask (mismatch_mask),
        .sel_err       (sel_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        tests_run++;
        if (got !== want) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    // Issue one request, check latency to done, then step into the first IDLE cycle.
    task automatic req(input logic [2:0] f, input logic c, input logic [7:0] e, input int lat);
        int n;
        @(negedge clk);
        fn_sel   = f;
        check_en = c;
        expected = e;
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        n = 1;
        while (!done && n < 20) begin
            @(posedge clk);
            #1 n++;
        end
        check("latency", 32'(n), 32'(lat));
        check("busy_at_done", 32'(busy), 32'd1);
        @(posedge clk);
        #1;
        check("busy_after", 32'(busy), 32'd0);
        check("done_pulse", 32'(done), 32'd0);
    endtask

    logic [7:0] gold [6];

    initial begin
        int ndone;
        tests_run    = 0;
        tests_failed = 0;
        gold[0] = 8'h1F; gold[1] = 8'h20; gold[2] = 8'h04;
        gold[3] = 8'h8A; gold[4] = 8'h2A; gold[5] = 8'hCE;
        rst_n    = 1'b0;
        start    = 1'b0;
        fn_sel   = 3'd0;
        check_en = 1'b0;
        expected = 8'h00;
        #23;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_xyz", 32'({x, y, z}), 32'd0);
        check("rst_table", 32'(table_out), 32'd0);
        check("rst_sel_err", 32'(sel_err), 32'd0);
        rst_n = 1'b1;

        // Full sweep with per-cycle minterm check
        @(negedge clk);
        fn_sel = 3'd0; check_en = 1'b0; expected = 8'hFF; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            check($sformatf("xyz_c%0d", k + 1), 32'({x, y, z}), 32'(k));
            check($sformatf("busy_c%0d", k + 1), 32'(busy), 32'd1);
            check($sformatf("nodone_c%0d", k + 1), 32'(done), 32'd0);
            @(posedge clk);
            #1;
        end
        check("done_c9", 32'(done), 32'd1);
        check("xyz_c9", 32'({x, y, z}), 32'd0);
        check("ex_table", 32'(table_out), 32'h1F);
        check("ex_mismatch", 32'(mismatch), 32'd0);
        check("ex_mask", 32'(mismatch_mask), 32'd0);
        @(posedge clk);
        #1 check("idle_xyz", 32'({x, y, z}), 32'd0);

        // Every legal function against its golden table
        for (int f = 0; f < 6; f++) begin
            req(3'(f), 1'b1, gold[f], 9);
            check($sformatf("tbl_fn%0d", f), 32'(table_out), 32'(gold[f]));
            check($sformatf("mm_fn%0d", f), 32'(mismatch), 32'd0);
            check($sformatf("mask_fn%0d", f), 32'(mismatch_mask), 32'd0);
        end

        // Single-bit mismatch
        req(3'd3, 1'b1, 8'h8B, 9);
        check("mm_table", 32'(table_out), 32'h8A);
        check("mm_flag", 32'(mismatch), 32'd1);
        check("mm_mask", 32'(mismatch_mask), 32'h01);

        // Illegal select, then recovery
        req(3'd6, 1'b0, 8'h00, 1);
        check("ill_sel_err", 32'(sel_err), 32'd1);
        check("ill_table", 32'(table_out), 32'd0);
        check("ill_mismatch", 32'(mismatch), 32'd0);
        req(3'd1, 1'b1, 8'h20, 9);
        check("rec_sel_err", 32'(sel_err), 32'd0);
        check("rec_table", 32'(table_out), 32'h20);

        // start held through sweep; inputs change mid-sweep
        @(negedge clk);
        fn_sel = 3'd3; check_en = 1'b1; expected = 8'h8A; start = 1'b1;
        @(posedge clk);
        ndone = 0;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            if (c == 4) begin
                fn_sel = 3'd4; expected = 8'h00; check_en = 1'b0;
            end
            if (done) begin
                ndone++;
                start = 1'b0;
            end
        end
        check("hold_ndone", 32'(ndone), 32'd1);
        check("hold_table", 32'(table_out), 32'h8A);
        check("hold_mismatch", 32'(mismatch), 32'd0);

        // start in the first cycle after done is accepted
        req(3'd2, 1'b0, 8'h00, 9);
        @(negedge clk);
        fn_sel = 3'd5; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        check("b2b_busy", 32'(busy), 32'd1);
        repeat (9) @(posedge clk);
        #1 check("b2b_table", 32'(table_out), 32'hCE);

        // Reset mid-sweep clears everything asynchronously
        req(3'd3, 1'b1, 8'h8B, 9);
        @(negedge clk);
        fn_sel = 3'd5; check_en = 1'b1; expected = 8'h00; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("pre_rst_xyz", 32'({x, y, z}), 32'd3);
        rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_xyz", 32'({x, y, z}), 32'd0);
        check("arst_table", 32'(table_out), 32'd0);
        check("arst_mismatch", 32'(mismatch), 32'd0);
        check("arst_mask", 32'(mismatch_mask), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1 check("post_rst_busy", 32'(busy), 32'd0);
        req(3'd5, 1'b1, 8'hCE, 9);
        check("post_rst_table", 32'(table_out), 32'hCE);
        check("post_rst_mm", 32'(mismatch), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
